// File: rtl/inst_buffer_array.sv
// Per-warp two-entry instruction buffer between decode and the warp issue arbiter.
// Optional sticky illegal-request flag err_o is built when INST_BUF_ERR_EN is defined.
module inst_buffer_array #(
   parameter int NUM_WARP      = 4,
   parameter int NUM_WARP_LOG  = 2,
   parameter int NUM_ENTRY_LOG = 1,
   parameter int INST_W        = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid_i,
   input  logic [NUM_WARP_LOG-1:0]  wr_warp_i,
   input  logic [INST_W-1:0]        wr_inst_i,
   output logic                     wr_ready_o,
   input  logic                     flush_i,
   input  logic [NUM_WARP_LOG-1:0]  flush_warp_i,
   output logic [NUM_WARP-1:0]      ReadyVector0_o,
   output logic [NUM_WARP-1:0]      ReadyVector1_o,
   output logic [NUM_WARP_LOG-1:0]  preWarp_o,
   input  logic                     issue_en_i,
   input  logic [NUM_WARP_LOG-1:0]  grantWarp_i,
   input  logic [NUM_ENTRY_LOG-1:0] grantEntry_i,
   output logic                     issue_valid_o,
   output logic [NUM_WARP_LOG-1:0]  issue_warp_o,
   output logic [INST_W-1:0]        issue_inst_o
`ifdef INST_BUF_ERR_EN
   ,output logic                    err_o
`endif
);

   logic [NUM_WARP-1:0] valid0, valid1, valid0Next, valid1Next;
   logic [INST_W-1:0]   inst0 [NUM_WARP];
   logic [INST_W-1:0]   inst1 [NUM_WARP];

   logic wrFree0, wrFree1, wrFlushHit, wrEn, wrSel;
   logic grantSel, grantValid, issueFlushHit, issueEn;
   logic [INST_W-1:0] grantInst;

   // Freeness comes from start-of-cycle state, so an entry being issued now is not reusable.
   assign wrFree0    = !valid0[wr_warp_i];
   assign wrFree1    = !valid1[wr_warp_i];
   assign wrFlushHit = flush_i && (flush_warp_i == wr_warp_i);
   assign wr_ready_o = (wrFree0 || wrFree1) && !wrFlushHit;
   assign wrEn       = wr_valid_i && wr_ready_o;
   assign wrSel      = !wrFree0;

   assign grantSel      = (grantEntry_i != '0);
   assign grantValid    = grantSel ? valid1[grantWarp_i] : valid0[grantWarp_i];
   assign grantInst     = grantSel ? inst1[grantWarp_i]  : inst0[grantWarp_i];
   assign issueFlushHit = flush_i && (flush_warp_i == grantWarp_i);
   assign issueEn       = issue_en_i && grantValid && !issueFlushHit;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      valid0Next = valid0;
      valid1Next = valid1;
      if (wrEn && !wrSel) valid0Next[wr_warp_i] = 1'b1;
      if (wrEn &&  wrSel) valid1Next[wr_warp_i] = 1'b1;
      if (issueEn && !grantSel) valid0Next[grantWarp_i] = 1'b0;
      if (issueEn &&  grantSel) valid1Next[grantWarp_i] = 1'b0;
      if (flush_i) begin
         valid0Next[flush_warp_i] = 1'b0;
         valid1Next[flush_warp_i] = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid0        <= '0;
         valid1        <= '0;
         preWarp_o     <= '0;
         issue_valid_o <= 1'b0;
         issue_warp_o  <= '0;
         issue_inst_o  <= '0;
      end else begin
         valid0        <= valid0Next;
         valid1        <= valid1Next;
         issue_valid_o <= issueEn;
         if (issueEn) begin
            preWarp_o    <= grantWarp_i;
            issue_warp_o <= grantWarp_i;
            issue_inst_o <= grantInst;
         end
      end
   end

   // NOTE: the instruction words are not reset; the valid bits alone decide whether a word is meaningful.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         if (wrSel) inst1[wr_warp_i] <= wr_inst_i;
         else       inst0[wr_warp_i] <= wr_inst_i;
      end
   end

   assign ReadyVector0_o = valid0;
   assign ReadyVector1_o = valid1;

`ifdef INST_BUF_ERR_EN
   logic errSet;
   assign errSet = (wr_valid_i && !wr_ready_o && !wrFlushHit) || (issue_en_i && !grantValid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      err_o <= 1'b0;
      else if (errSet) err_o <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_inst_buffer_array.sv
// Directed self-checking bench for inst_buffer_array; checks err_o too when INST_BUF_ERR_EN is defined.
module tb_inst_buffer_array;

   logic        clk = 1'b0;
   logic        reset;
   logic        wrValid;
   logic [1:0]  wrWarp;
   logic [31:0] wrInst;
   logic        wrReady;
   logic        flush;
   logic [1:0]  flushWarp;
   logic [3:0]  rv0, rv1;
   logic [1:0]  preWarp;
   logic        issueEn;
   logic [1:0]  grantWarp;
   logic [0:0]  grantEntry;
   logic        issueValid;
   logic [1:0]  issueWarp;
   logic [31:0] issueInst;
`ifdef INST_BUF_ERR_EN
   logic        err;
`endif

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   inst_buffer_array dut (
      .clk            (clk),
      .reset          (reset),
      .wr_valid_i     (wrValid),
      .wr_warp_i      (wrWarp),
      .wr_inst_i      (wrInst),
      .wr_ready_o     (wrReady),
      .flush_i        (flush),
      .flush_warp_i   (flushWarp),
      .ReadyVector0_o (rv0),
      .ReadyVector1_o (rv1),
      .preWarp_o      (preWarp),
      .issue_en_i     (issueEn),
      .grantWarp_i    (grantWarp),
      .grantEntry_i   (grantEntry),
      .issue_valid_o  (issueValid),
      .issue_warp_o   (issueWarp),
      .issue_inst_o   (issueInst)
`ifdef INST_BUF_ERR_EN
      ,.err_o         (err)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nTests++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wrValid = 1'b0; wrWarp = '0; wrInst = '0;
      flush = 1'b0; flushWarp = '0;
      issueEn = 1'b0; grantWarp = '0; grantEntry = '0;
   endtask

   task automatic doWrite(input logic [1:0] w, input logic [31:0] d);
      wrValid = 1'b1; wrWarp = w; wrInst = d;
   endtask

   task automatic doIssue(input logic [1:0] w, input logic e);
      issueEn = 1'b1; grantWarp = w; grantEntry = e;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      #3;
      chk("rst_rv0", rv0, 4'b0000);
      chk("rst_rv1", rv1, 4'b0000);
      chk("rst_prewarp", preWarp, 2'd0);
      chk("rst_issue_valid", issueValid, 1'b0);
      chk("rst_issue_warp", issueWarp, 2'd0);
      chk("rst_issue_inst", issueInst, 32'h0);
      #9 reset = 1'b1;
      tick();

      // single write to warp 2
      doWrite(2'd2, 32'hA5A5_0001);
      #1 chk("w2_ready", wrReady, 1'b1);
      tick(); idle();
      chk("w2_rv0", rv0, 4'b0100);
      chk("w2_rv1", rv1, 4'b0000);

      // warp 1 filled, third write dropped
      doWrite(2'd1, 32'h11); tick();
      doWrite(2'd1, 32'h12); tick();
      doWrite(2'd1, 32'h13);
      #1 chk("w1_full_ready", wrReady, 1'b0);
      tick(); idle();
      chk("w1_rv0", rv0, 4'b0110);
      chk("w1_rv1", rv1, 4'b0010);

      // write then issue warp 3
      doWrite(2'd3, 32'h1234); tick(); idle();
      doIssue(2'd3, 1'b0); tick(); idle();
      chk("i3_valid", issueValid, 1'b1);
      chk("i3_warp", issueWarp, 2'd3);
      chk("i3_inst", issueInst, 32'h1234);
      chk("i3_prewarp", preWarp, 2'd3);
      chk("i3_rv0", rv0, 4'b0110);
      tick();
      chk("i3_valid_drop", issueValid, 1'b0);
      chk("i3_inst_hold", issueInst, 32'h1234);
      chk("i3_prewarp_hold", preWarp, 2'd3);

      // warp 0 full: issue entry 1 and write in the same cycle
      doWrite(2'd0, 32'h100); tick();
      doWrite(2'd0, 32'h101); tick(); idle();
      chk("w0_full_rv1", rv1, 4'b0011);
      doIssue(2'd0, 1'b1); doWrite(2'd0, 32'h102);
      #1 chk("w0_wr_issue_ready", wrReady, 1'b0);
      tick(); idle();
      chk("i01_inst", issueInst, 32'h101);
      chk("i01_warp", issueWarp, 2'd0);
      chk("i01_rv1", rv1, 4'b0010);
      doWrite(2'd0, 32'h103);
      #1 chk("w0_refill_ready", wrReady, 1'b1);
      tick(); idle();
      chk("w0_refill_rv1", rv1, 4'b0011);
      doIssue(2'd0, 1'b1); tick(); idle();
      chk("i01b_inst", issueInst, 32'h103);
      doIssue(2'd0, 1'b0); tick(); idle();
      chk("i00_inst", issueInst, 32'h100);
      chk("w0_empty_rv0", rv0, 4'b0110);
      // warp 1 drop check: entry 1 must still hold the second write
      // (done below together with independent-warp traffic)

      // write, issue and flush on three different warps at once
      doWrite(2'd0, 32'h0F0); tick(); idle();
      doWrite(2'd3, 32'h333); doIssue(2'd1, 1'b1); flush = 1'b1; flushWarp = 2'd0;
      #1 chk("indep_ready", wrReady, 1'b1);
      tick(); idle();
      chk("indep_issue_valid", issueValid, 1'b1);
      chk("indep_issue_inst", issueInst, 32'h12);
      chk("indep_prewarp", preWarp, 2'd1);
      chk("indep_rv0", rv0, 4'b1110);
      chk("indep_rv1", rv1, 4'b0000);

      // flush warp 2 beats both issue and write to warp 2
      doWrite(2'd2, 32'h202); tick(); idle();
      chk("w2b_rv1", rv1, 4'b0100);
      flush = 1'b1; flushWarp = 2'd2; doIssue(2'd2, 1'b0); doWrite(2'd2, 32'h2FF);
      #1 chk("flush_wr_ready", wrReady, 1'b0);
      tick(); idle();
      chk("flush_issue_valid", issueValid, 1'b0);
      chk("flush_rv0", rv0, 4'b1010);
      chk("flush_rv1", rv1, 4'b0000);
      chk("flush_prewarp", preWarp, 2'd1);
      chk("flush_inst_hold", issueInst, 32'h12);

      // reset during activity
      doWrite(2'd2, 32'h222); tick();
      doWrite(2'd0, 32'h400); tick(); idle();
      chk("pre_rst_rv0", rv0, 4'b1111);
      doIssue(2'd1, 1'b0); tick(); idle();
      chk("pre_rst_issue_valid", issueValid, 1'b1);
      chk("pre_rst_issue_inst", issueInst, 32'h11);
      chk("pre_rst_rv0b", rv0, 4'b1101);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_rv0", rv0, 4'b0000);
      chk("async_rst_issue_valid", issueValid, 1'b0);
      chk("async_rst_issue_warp", issueWarp, 2'd0);
      chk("async_rst_issue_inst", issueInst, 32'h0);
      chk("async_rst_prewarp", preWarp, 2'd0);
      @(negedge clk) reset = 1'b1;
      tick();

      // grant to an empty entry is ignored
`ifdef INST_BUF_ERR_EN
      chk("err_init", err, 1'b0);
`endif
      doIssue(2'd3, 1'b0); tick(); idle();
      chk("bad_grant_issue_valid", issueValid, 1'b0);
      chk("bad_grant_rv0", rv0, 4'b0000);
`ifdef INST_BUF_ERR_EN
      chk("err_set", err, 1'b1);
      tick();
      chk("err_sticky", err, 1'b1);
      #2 reset = 1'b0;
      #1 chk("err_rst", err, 1'b0);
      @(negedge clk) reset = 1'b1;
`endif
      tick();

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
